two_to_1mux_rr_arbiter: RTL and testbench
=========================================

# two_to_1mux_rr_arbiter

Round-robin arbiter and sequencer for the shared 2:1 data multiplexer. Two requesters each present a data word with a req/ack handshake. The block picks one requester, drives the mux select `s0`, latches the selected word into an output register, and holds it under a valid/ready handshake until the consumer accepts it. It sits between the requester pair and the downstream consumer and is the only driver of the mux select.

## Interface
- `WIDTH`, 8: data word width for `a0`, `a1`, `y0`.
- `CNT_W`, 16: width of the completed-transfer counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  requester 0 has a word on `a0`; held until `ack0`.
- `req1`  in  1  requester 1 has a word on `a1`; held until `ack1`.
- `a0`  in  WIDTH  requester 0 data; must be stable while `req0` is high.
- `a1`  in  WIDTH  requester 1 data; must be stable while `req1` is high.
- `ack0`  out  1  one-cycle pulse when the `a0` word has been captured.
- `ack1`  out  1  one-cycle pulse when the `a1` word has been captured.
- `s0`  out  1  mux select, registered; 0 selects `a0`, 1 selects `a1`.
- `y0`  out  WIDTH  registered output word.
- `y_valid`  out  1  `y0` holds an unaccepted word.
- `y_ready`  in  1  consumer accepts `y0` when `y_valid` and `y_ready` are both high at a rising edge.
- `busy`  out  1  high in any state other than IDLE.
- `xfer_cnt`  out  CNT_W  number of completed output transfers; wraps modulo 2^CNT_W.

## Operation
- **States:** IDLE, GRANT0, GRANT1. Encoding is a 2-bit enum.
- **Reset values:** state=IDLE, `s0`=0, `y0`=0, `y_valid`=0, `ack0`=0, `ack1`=0, `busy`=0, `xfer_cnt`=0, `last`=1. `last` is the internal pointer to the last-served requester; its reset value makes requester 0 win the first contention.
- **IDLE:**
  - Only `req0` high -> GRANT0.
  - Only `req1` high -> GRANT1.
  - Both high -> grant the requester ≠ `last`.
  - Neither high -> stay in IDLE, outputs held.
- **On entering GRANTx (same edge):**
  - `s0` <= x.
  - `y0` <= `ax`.
  - `y_valid` <= 1.
  - `ackx` <= 1 for exactly one cycle.
  - `last` <= x.
- **GRANTx:** hold `y0` and `s0`. On the edge where `y_valid && y_ready`:
  - `y_valid` <= 0.
  - `xfer_cnt` <= `xfer_cnt` + 1, wrapping to 0 after all ones.
  - Return to IDLE.
  - Otherwise remain in GRANTx indefinitely; no timeout.
- **Requests during a grant:** ignored until IDLE. A `req` that drops before it is granted is lost with no error.
- **After `ackx`:** a requester deasserts `req` or presents a new word. A `req` still high in IDLE is treated as a new request.
- **`s0` in IDLE:** holds its last value.
- **Reset mid-grant:** the pending `y0` word is discarded, `y_valid` drops immediately (asynchronously), and `xfer_cnt` clears.

## Timing
- **Request to output latency:** 1 cycle. A `req` sampled at edge N gives `y_valid`, `y0`, `s0` and `ack` valid after edge N.
- **Throughput:** at most one transfer per 2 cycles, because IDLE is always visited between grants.
- **Fairness:** under continuous dual requests with `y_ready`=1, grants alternate 0,1,0,1 with a 2-cycle period per grant.
- **`ack` pulse:** exactly one cycle, coincident with the first cycle of `y_valid`.
- **Output stability:** `y0` and `s0` do not change while `y_valid`=1.

## Structure
- **Shared package `mux_arb_pkg`:**
  - State enum `arb_state_t` (IDLE, GRANT0, GRANT1).
  - Constants `SEL_A0`=0 and `SEL_A1`=1.
- **Sub-module `rr_pick2`:** a combinational 2-way round-robin picker with inputs `req0`, `req1`, `last` and outputs `gnt_valid`, `gnt_sel`. It is the natural sub-module. The state machine, output register and counter stay in the top module.

## Test plan
- **Reset:** assert `rst` mid-simulation with `req0`=1. Require all outputs at their reset values immediately and `xfer_cnt`=0.
- **Single requester:** `req0`=1, `a0`=8'hA5, `y_ready`=1. Require:
  - the next cycle shows `ack0`=1, `y0`=A5, `s0`=0, `y_valid`=1;
  - one cycle later, `y_valid`=0 and `xfer_cnt`=1.
- **Contention after reset:** both requests high, `a0`=8'h11, `a1`=8'h22, `y_ready`=1. Require outputs 11, 22, 11, 22 with alternating `ack0`/`ack1` and `s0` toggling 0,1,0,1.
- **Backpressure:** grant `a1`=8'h3C with `y_ready`=0 for 5 cycles and change `req0`/`a0` meanwhile. Require:
  - `y0`=3C, `s0`=1 and `y_valid`=1 held stable;
  - no `ack0` pulse;
  - transfer completes on the first `y_ready`=1.
- **Counter wrap:** with `CNT_W`=4, perform 17 transfers. Require `xfer_cnt`=1.
- **Reset mid-grant:** assert `rst` while in GRANT1 with `y_ready`=0. Require `y_valid`=0 and `busy`=0 asynchronously, then after release, requester 0 wins the next contention.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and select constants for the 2:1 mux round-robin arbiter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic SEL_A0 = 1'b0;
  localparam logic SEL_A1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way round-robin picker
module rr_pick2
  import mux_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_sel
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_sel   = SEL_A0;
    // On contention the requester not served last time wins.
    if (req0 && req1) begin
      gnt_sel = ~last;
    end else if (req1) begin
      gnt_sel = SEL_A1;
    end
  end

endmodule

// File: rtl/two_to_1mux_rr_arbiter.sv
// rtl/two_to_1mux_rr_arbiter.sv - round-robin sequencer driving the shared 2:1 mux select and output register
module two_to_1mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic             ack0,
  output logic             ack1,
  output logic             s0,
  output logic [WIDTH-1:0] y0,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;
  logic       gnt_valid;
  logic       gnt_sel;
  logic       load;
  logic       accept;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_nxt = (gnt_sel == SEL_A1) ? GRANT1 : GRANT0;
          load      = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (y_valid && y_ready) begin
          state_nxt = IDLE;
          accept    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s0       <= SEL_A0;
      y0       <= '0;
      y_valid  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      xfer_cnt <= '0;
      last     <= 1'b1;
    end else begin
      state <= state_nxt;
      ack0  <= load && (gnt_sel == SEL_A0);
      ack1  <= load && (gnt_sel == SEL_A1);
      if (load) begin
        s0      <= gnt_sel;
        y0      <= (gnt_sel == SEL_A1) ? a1 : a0;
        y_valid <= 1'b1;
        last    <= gnt_sel;
      end else if (accept) begin
        y_valid  <= 1'b0;
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_two_to_1mux_rr_arbiter.sv
// tb/tb_two_to_1mux_rr_arbiter.sv - table-driven self-checking bench for two_to_1mux_rr_arbiter
module tb_two_to_1mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] a0 = 8'h00;
  logic [7:0] a1 = 8'h00;
  logic       y_ready = 1'b0;

  logic        ack0, ack1, s0, y_valid, busy;
  logic [7:0]  y0;
  logic [15:0] xfer_cnt;

  logic        w_ack0, w_ack1, w_s0, w_y_valid, w_busy;
  logic [7:0]  w_y0;
  logic [3:0]  w_xfer_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  two_to_1mux_rr_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
    .ack0(ack0), .ack1(ack1), .s0(s0), .y0(y0), .y_valid(y_valid),
    .y_ready(y_ready), .busy(busy), .xfer_cnt(xfer_cnt)
  );

  two_to_1mux_rr_arbiter #(.WIDTH(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
    .ack0(w_ack0), .ack1(w_ack1), .s0(w_s0), .y0(w_y0), .y_valid(w_y_valid),
    .y_ready(y_ready), .busy(w_busy), .xfer_cnt(w_xfer_cnt)
  );

  typedef struct {
    logic        rst, req0, req1;
    logic [7:0]  a0, a1;
    logic        rdy;
    logic        ack0, ack1, s0;
    logic [7:0]  y0;
    logic        vld, busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic q0, logic q1, logic [7:0] d0, logic [7:0] d1,
                              logic rd, logic k0, logic k1, logic s, logic [7:0] y,
                              logic v, logic b, logic [15:0] c);
    vec_t t;
    t.rst = r; t.req0 = q0; t.req1 = q1; t.a0 = d0; t.a1 = d1; t.rdy = rd;
    t.ack0 = k0; t.ack1 = k1; t.s0 = s; t.y0 = y; t.vld = v; t.busy = b; t.cnt = c;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst req0 req1 a0 a1 rdy | ack0 ack1 s0 y0 vld busy cnt
    vecs.push_back(mk(1,1,0,8'hA5,8'h00,1, 0,0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,0,8'hA5,8'h00,1, 1,0,0,8'hA5,1,1,0));
    vecs.push_back(mk(0,0,0,8'hA5,8'h00,1, 0,0,0,8'hA5,0,0,1));
    vecs.push_back(mk(1,1,1,8'h11,8'h22,1, 0,0,0,8'h00,0,0,0));
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 1,0,0,8'h11,1,1,0));
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 0,0,0,8'h11,0,0,1));
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 0,1,1,8'h22,1,1,1));
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 0,0,1,8'h22,0,0,2));
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 1,0,0,8'h11,1,1,2));
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 0,0,0,8'h11,0,0,3));
    vecs.push_back(mk(0,1,1,8'h11,8'h22,1, 0,1,1,8'h22,1,1,3));
    vecs.push_back(mk(0,0,0,8'h11,8'h22,1, 0,0,1,8'h22,0,0,4));
    vecs.push_back(mk(0,0,0,8'h11,8'h22,1, 0,0,1,8'h22,0,0,4));
    // backpressure: a1 granted, consumer stalls while requester 0 churns
    vecs.push_back(mk(0,0,1,8'h11,8'h3C,0, 0,1,1,8'h3C,1,1,4));
    vecs.push_back(mk(0,1,0,8'h55,8'h3C,0, 0,0,1,8'h3C,1,1,4));
    vecs.push_back(mk(0,1,0,8'h66,8'h3C,0, 0,0,1,8'h3C,1,1,4));
    vecs.push_back(mk(0,1,0,8'h77,8'h3C,0, 0,0,1,8'h3C,1,1,4));
    vecs.push_back(mk(0,1,0,8'h88,8'h3C,0, 0,0,1,8'h3C,1,1,4));
    vecs.push_back(mk(0,1,0,8'h88,8'h3C,1, 0,0,1,8'h3C,0,0,5));
    vecs.push_back(mk(0,1,0,8'h88,8'h3C,1, 1,0,0,8'h88,1,1,5));
    vecs.push_back(mk(0,0,0,8'h88,8'h3C,1, 0,0,0,8'h88,0,0,6));

    step();
    step();

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req0 = vecs[i].req0; req1 = vecs[i].req1;
      a0 = vecs[i].a0; a1 = vecs[i].a1; y_ready = vecs[i].rdy;
      step();
      chk($sformatf("v%0d ack0", i), 32'(ack0), 32'(vecs[i].ack0));
      chk($sformatf("v%0d ack1", i), 32'(ack1), 32'(vecs[i].ack1));
      chk($sformatf("v%0d s0", i), 32'(s0), 32'(vecs[i].s0));
      chk($sformatf("v%0d y0", i), 32'(y0), 32'(vecs[i].y0));
      chk($sformatf("v%0d y_valid", i), 32'(y_valid), 32'(vecs[i].vld));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d xfer_cnt", i), 32'(xfer_cnt), 32'(vecs[i].cnt));
    end

    // asynchronous reset while GRANT1 is stalled
    req0 = 1'b0; req1 = 1'b1; a1 = 8'h99; y_ready = 1'b0;
    step();
    chk("midgrant pre y_valid", 32'(y_valid), 32'd1);
    chk("midgrant pre s0", 32'(s0), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async y_valid", 32'(y_valid), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async y0", 32'(y0), 32'd0);
    chk("async s0", 32'(s0), 32'd0);
    chk("async xfer_cnt", 32'(xfer_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; a0 = 8'hAA; a1 = 8'hBB; y_ready = 1'b1;
    step();
    chk("post-reset ack0", 32'(ack0), 32'd1);
    chk("post-reset ack1", 32'(ack1), 32'd0);
    chk("post-reset y0", 32'(y0), 32'hAA);
    chk("post-reset s0", 32'(s0), 32'd0);

    // counter wrap: 17 back-to-back transfers from requester 0
    rst = 1'b1;
    step();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0; a0 = 8'h5A; y_ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      step();
      if (i == 31) begin
        chk("wrap16 cnt4", 32'(w_xfer_cnt), 32'd0);
        chk("wrap16 cnt16", 32'(xfer_cnt), 32'd16);
      end
    end
    chk("wrap17 cnt4", 32'(w_xfer_cnt), 32'd1);
    chk("wrap17 cnt16", 32'(xfer_cnt), 32'd17);
    chk("wrap17 y_valid", 32'(w_y_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
